// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: FSM encoding, next-PC select encoding
// and the jump-target helper used by the next-PC mux.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_PC4 = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } next_sel_e;

  // j/jal stay inside the 256 MB region of the delay-slot PC held in IF/ID.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_mux.sv
// Combinational next-PC selection: jr > branch > jump > pc+4, with target formation.
module fetch_unit_pc_next_mux
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ifid_pc4,
  input  logic        pc_src,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        redirect
);

  next_sel_e sel;

  always_comb begin
    sel = SEL_PC4;
    if (jr)          sel = SEL_JR;
    else if (pc_src) sel = SEL_BR;
    else if (jump)   sel = SEL_J;
  end

  assign pc_plus4 = pc + 32'd4;
  assign redirect = (sel != SEL_PC4);

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_JR:  next_pc = jr_target & ~32'd3;
      SEL_BR:  next_pc = br_target;
      SEL_J:   next_pc = jump_target(ifid_pc4, jump_index);
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// MIPS IF stage: owns the PC, reads the I-cache, drives IF/ID, and parks
// redirects/flushes that arrive while the cache is stalled.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         icache_stall,
  input  logic         hazard_stall,
  input  logic         pc_src,
  input  logic [31:0]  br_target,
  input  logic         jump,
  input  logic [25:0]  jump_index,
  input  logic         jr,
  input  logic [31:0]  jr_target,
  input  logic         if_flush,
  output logic         icache_ren,
  output logic [29:0]  icache_addr,
  input  logic [31:0]  icache_rdata,
  output logic [31:0]  ifid_inst,
  output logic [31:0]  ifid_pc4,
  output logic         ifid_valid,
  output fetch_state_e fsm_state
);

  // Cache handshake: a word is transferred on every rising edge where
  // icache_ren=1 and icache_stall=0; while stalled the request (ren, addr)
  // is held unchanged, and dropping ren abandons it.

  fetch_state_e state, state_next;
  logic [31:0]  pc;
  logic [31:0]  pend_pc;
  logic         pend_v;
  logic         pend_flush;
  logic [31:0]  pc_plus4;
  logic [31:0]  mux_pc;
  logic         redirect;

  fetch_unit_pc_next_mux u_pc_next_mux (
    .pc         (pc),
    .ifid_pc4   (ifid_pc4),
    .pc_src     (pc_src),
    .br_target  (br_target),
    .jump       (jump),
    .jump_index (jump_index),
    .jr         (jr),
    .jr_target  (jr_target),
    .pc_plus4   (pc_plus4),
    .next_pc    (mux_pc),
    .redirect   (redirect)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (icache_stall)  state_next = MISS;
      MISS:    if (!icache_stall) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  assign icache_ren  = (state != BOOT);
  assign icache_addr = pc[31:2];
  assign fsm_state   = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      pend_pc    <= 32'd0;
      pend_v     <= 1'b0;
      pend_flush <= 1'b0;
      ifid_inst  <= NOP_INST;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
    end else if (state != BOOT) begin
      if (icache_stall) begin
        // Frozen pipeline: remember the latest redirect/flush for later.
        if (redirect) begin
          pend_pc <= mux_pc;
          pend_v  <= 1'b1;
        end
        if (if_flush) pend_flush <= 1'b1;
      end else begin
        pend_v     <= 1'b0;
        pend_flush <= 1'b0;
        if (redirect)          pc <= mux_pc;
        else if (pend_v)       pc <= pend_pc;
        else if (!hazard_stall) pc <= pc_plus4;
        if (if_flush || pend_flush) begin
          ifid_inst  <= NOP_INST;
          ifid_pc4   <= 32'd0;
          ifid_valid <= 1'b0;
        end else if (!hazard_stall) begin
          ifid_inst  <= icache_rdata;
          ifid_pc4   <= pc_plus4;
          ifid_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the driver pushes hand-computed per-cycle
// expectations tagged with their cycle; a negedge monitor pops and compares.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int W = 114;  // {cycle16, ren, addr30, valid, inst32, pc4_32, state2}

  logic         clk;
  logic         rst_n;
  logic         icache_stall;
  logic         hazard_stall;
  logic         pc_src;
  logic [31:0]  br_target;
  logic         jump;
  logic [25:0]  jump_index;
  logic         jr;
  logic [31:0]  jr_target;
  logic         if_flush;
  logic         icache_ren;
  logic [29:0]  icache_addr;
  logic [31:0]  icache_rdata;
  logic [31:0]  ifid_inst;
  logic [31:0]  ifid_pc4;
  logic         ifid_valid;
  fetch_state_e fsm_state;

  logic [W-1:0] exp_q[$];
  logic [15:0]  cyc;
  int           n_checks;
  int           n_fails;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icache_stall (icache_stall),
    .hazard_stall (hazard_stall),
    .pc_src       (pc_src),
    .br_target    (br_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_target    (jr_target),
    .if_flush     (if_flush),
    .icache_ren   (icache_ren),
    .icache_addr  (icache_addr),
    .icache_rdata (icache_rdata),
    .ifid_inst    (ifid_inst),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Instruction memory: each word encodes its own word address.
  function automatic logic [31:0] inst_of(input logic [29:0] a);
    return {2'b10, a};
  endfunction

  assign icache_rdata = inst_of(icache_addr);

  // driver tasks
  task automatic clear_ctl();
    pc_src     = 1'b0;
    br_target  = 32'd0;
    jump       = 1'b0;
    jump_index = 26'd0;
    jr         = 1'b0;
    jr_target  = 32'd0;
    if_flush   = 1'b0;
    hazard_stall = 1'b0;
  endtask

  // Expectation for the outputs right after the next rising edge.
  task automatic tick(input logic ren, input logic [29:0] addr, input logic v,
                      input logic [31:0] pc4, input fetch_state_e st);
    logic [29:0] src;
    logic [31:0] inst;
    src  = pc4[31:2] - 30'd1;
    inst = v ? inst_of(src) : 32'd0;
    exp_q.push_back({cyc + 16'd1, ren, addr, v, inst, pc4, st});
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [97:0]  act;
    if (exp_q.size() > 0 && exp_q[0][113:98] <= cyc) begin
      e = exp_q.pop_front();
      act = {icache_ren, icache_addr, ifid_valid, ifid_inst, ifid_pc4, fsm_state};
      n_checks++;
      if (e[113:98] != cyc || act !== e[97:0]) begin
        n_fails++;
        $display("FAIL cycle%0d: got ren=%b addr=%h valid=%b inst=%h pc4=%h st=%0d, want ren=%b addr=%h valid=%b inst=%h pc4=%h st=%0d (tag %0d)",
                 cyc, act[97], act[96:67], act[66], act[65:34], act[33:2], act[1:0],
                 e[97], e[96:67], e[66], e[65:34], e[33:2], e[1:0], e[113:98]);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0;
    icache_stall = 1'b0;
    clear_ctl();
    @(posedge clk);
    #1;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) tick(1'b0, 30'd0, 1'b0, 32'd0, BOOT);

    // Release: BOOT->RUN, then sequential fetch up to pc=0x20.
    rst_n = 1'b1;
    tick(1'b1, 30'd0, 1'b0, 32'd0, RUN);
    for (int k = 1; k <= 8; k++) tick(1'b1, 30'(k), 1'b1, 32'(4 * k), RUN);

    // Taken branch from pc=0x20 to 0x40 with flush.
    pc_src = 1'b1; br_target = 32'h40; if_flush = 1'b1;
    tick(1'b1, 30'h10, 1'b0, 32'd0, RUN);
    clear_ctl();
    tick(1'b1, 30'h11, 1'b1, 32'h44, RUN);
    tick(1'b1, 30'h12, 1'b1, 32'h48, RUN);

    // Priority: jr beats branch and jump; jr target is word aligned.
    jr = 1'b1; jr_target = 32'h103; pc_src = 1'b1; br_target = 32'h80;
    jump = 1'b1; jump_index = 26'h155;
    tick(1'b1, 30'h40, 1'b1, 32'h4C, RUN);
    clear_ctl();
    tick(1'b1, 30'h41, 1'b1, 32'h104, RUN);
    tick(1'b1, 30'h42, 1'b1, 32'h108, RUN);

    // Move to pc=0x3000_0004 so ifid_pc4 becomes 0x3000_0008.
    jr = 1'b1; jr_target = 32'h3000_0004; if_flush = 1'b1;
    tick(1'b1, 30'h0C00_0001, 1'b0, 32'd0, RUN);
    clear_ctl();
    tick(1'b1, 30'h0C00_0002, 1'b1, 32'h3000_0008, RUN);

    // Jump + flush during a 4-cycle miss; applied when the stall ends.
    icache_stall = 1'b1;
    tick(1'b1, 30'h0C00_0002, 1'b1, 32'h3000_0008, MISS);
    jump = 1'b1; jump_index = 26'h10; if_flush = 1'b1;
    tick(1'b1, 30'h0C00_0002, 1'b1, 32'h3000_0008, MISS);
    clear_ctl();
    tick(1'b1, 30'h0C00_0002, 1'b1, 32'h3000_0008, MISS);
    tick(1'b1, 30'h0C00_0002, 1'b1, 32'h3000_0008, MISS);
    icache_stall = 1'b0;
    tick(1'b1, 30'h0C00_0010, 1'b0, 32'd0, RUN);
    tick(1'b1, 30'h0C00_0011, 1'b1, 32'h3000_0044, RUN);

    // Load-use stall holds pc and IF/ID.
    hazard_stall = 1'b1;
    tick(1'b1, 30'h0C00_0011, 1'b1, 32'h3000_0044, RUN);
    clear_ctl();
    tick(1'b1, 30'h0C00_0012, 1'b1, 32'h3000_0048, RUN);
    // Flush beats hazard_stall: bubble, pc still held.
    hazard_stall = 1'b1; if_flush = 1'b1;
    tick(1'b1, 30'h0C00_0012, 1'b0, 32'd0, RUN);
    clear_ctl();
    tick(1'b1, 30'h0C00_0013, 1'b1, 32'h3000_004C, RUN);

    // Reset during a miss, with a redirect pending that must be dropped.
    icache_stall = 1'b1;
    jr = 1'b1; jr_target = 32'h0000_0800;
    tick(1'b1, 30'h0C00_0013, 1'b1, 32'h3000_004C, MISS);
    rst_n = 1'b0;
    tick(1'b0, 30'd0, 1'b0, 32'd0, BOOT);
    clear_ctl();
    rst_n = 1'b1; icache_stall = 1'b0;
    tick(1'b1, 30'd0, 1'b0, 32'd0, RUN);
    tick(1'b1, 30'd1, 1'b1, 32'd4, RUN);
    tick(1'b1, 30'd2, 1'b1, 32'd8, RUN);

    // pc+4 wraps modulo 2^32 at the top of the address space.
    jr = 1'b1; jr_target = 32'hFFFF_FFFF; if_flush = 1'b1;
    tick(1'b1, 30'h3FFF_FFFF, 1'b0, 32'd0, RUN);
    clear_ctl();
    tick(1'b1, 30'd0, 1'b1, 32'd0, RUN);
    tick(1'b1, 30'd1, 1'b1, 32'd4, RUN);

    // Drain the scoreboard.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, issues word reads to the instruction cache, and drives the IF/ID pipeline register. It consumes the redirect and flush controls produced by the ID-stage decoder: branch-taken, jump, jump-register and IF/ID flush. It also remembers any redirect or flush that arrives while the cache is stalled and applies it when the stall ends.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch; bits [1:0] must be 0.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- icache_stall  in  1  cache not ready; the whole pipeline freezes.
- hazard_stall  in  1  load-use stall from the hazard unit.
- pc_src  in  1  branch taken (decoder output, beq resolved in ID).
- br_target  in  32  branch target byte address.
- jump  in  1  j/jal redirect.
- jump_index  in  26  instruction[25:0] of the jump in ID.
- jr  in  1  jr/jalr redirect.
- jr_target  in  32  forwarded rs value.
- if_flush  in  1  squash the instruction currently in IF.
- icache_ren  out  1  read request.
- icache_addr  out  30  word address, equal to pc[31:2].
- icache_rdata  in  32  instruction word; valid when ren=1 and stall=0.
- ifid_inst  out  32  instruction to ID.
- ifid_pc4  out  32  PC+4 of ifid_inst.
- ifid_valid  out  1  ifid_inst is live (0 means bubble).

## Operation
- States:
  - BOOT: ren=0.
  - RUN: ren=1, stall=0 last cycle.
  - MISS: ren=1, waiting on icache_stall.
- Transitions:
  - BOOT→RUN on the first cycle with rst_n=1.
  - RUN→MISS when icache_stall=1.
  - MISS→RUN when icache_stall=0.
  - Any state→BOOT when rst_n=0.
- Next-PC priority: jr, then pc_src, then jump, then pc+4.
  - jr target: {jr_target[31:2],2'b00}.
  - jump target: {ifid_pc4[31:28], jump_index, 2'b00}.
  - All adds are 32-bit and wrap modulo 2^32; no overflow flag.
- Stall rules:
  - icache_stall=1: pc and the IF/ID register hold.
  - Any redirect asserted in that cycle loads pend_pc/pend_v, using the same priority; a later redirect overwrites an earlier one.
  - An if_flush asserted in that cycle sets pend_flush.
- First unstalled cycle with pend_v=1: pc ← pend_pc. A live redirect input in the same cycle beats pend_pc. pend_v clears.
- First unstalled cycle with pend_flush=1 (or if_flush=1): IF/ID is loaded with the bubble (inst=0, pc4=0, valid=0). pend_flush clears.
- hazard_stall=1 with icache_stall=0: pc holds and IF/ID holds, unless if_flush is set; flush beats hazard_stall and inserts the bubble.
- Redirects are honoured during hazard_stall. The branch sits in ID during a load-use stall only after its operands are ready, so the decoder's outputs are trusted.
- Normal advance: IF/ID ← {icache_rdata, pc+4, 1}; pc ← next-PC.

## Timing
- Reset values: pc=RESET_PC, icache_ren=0, icache_addr=RESET_PC[31:2], ifid_inst=0, ifid_pc4=0, ifid_valid=0, pend_v=0, pend_flush=0, state=BOOT.
- First cycle after rst_n rises: ren=1, addr=RESET_PC[31:2]. The first IF/ID load happens on the following edge if no stall.
- Fetch latency: the instruction read at edge N appears on ifid_inst after edge N+1 when no stall.
- Redirect latency: a redirect sampled at edge N changes icache_addr immediately after edge N (registered pc).
- rst_n=0 during MISS: all state returns to reset values on that edge. The outstanding read is abandoned; ren=0 tells the cache.
- icache_addr and ifid_* are registered. No combinational path from inputs to outputs except icache_addr = pc[31:2].

## Structure
- Shared package: NOP_INST=32'h0, the state encoding (BOOT/RUN/MISS, 2 bits), and the next-PC select encoding (SEL_PC4/SEL_BR/SEL_J/SEL_JR).
- One natural sub-module: pc_next_mux. It is combinational and does priority select plus target formation; the same unit is reused to compute pend_pc.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → all outputs at reset values. Release → ren=1, addr 0x0, then 0x1, 0x2 on successive cycles. ifid_pc4 shows 4, 8, ….
- Taken branch: with pc=0x20, pc_src=1, br_target=0x40, if_flush=1 → next addr=0x10. ifid_valid=0 for one cycle, then the inst from 0x40 with pc4=0x44.
- Priority: jr=1 (jr_target=0x103), pc_src=1 (0x80) and jump=1 in the same cycle → pc=0x100, addr=0x40.
- Redirect in miss: icache_stall=1 for 4 cycles; jump=1 with jump_index=0x10 (ifid_pc4=0x3000_0008) in cycle 2 only → pc holds during the stall. After the stall, pc=0x3000_0040 and IF/ID gets one bubble.
- Load-use: hazard_stall=1 for 1 cycle → pc and ifid_* unchanged. hazard_stall=1 together with if_flush=1 → bubble inserted.
- Reset mid-miss: rst_n=0 while in MISS → ren=0 next cycle, pc=RESET_PC, pend_v=0, fetch restarts from RESET_PC.
